wallace_final_adder: RTL and testbench

WALLACE_FINAL_ADDER -- requirements
Module: wallace_final_adder

---
 rtl/wallace_pkg.sv | 23 ++
 rtl/slice_adder16.sv | 25 ++
 rtl/wallace_final_adder.sv | 136 +++++++++++++
 tb/tb_wallace_final_adder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wallace_pkg.sv
// ============================================================================
// Module   : wallace_pkg
// Brief    : Shared widths, default tag width and FSM encoding for the
//            Wallace-tree final carry-propagate adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wallace_pkg;

    localparam int PROD_W        = 64;
    localparam int SLICE_W       = 16;
    localparam int TAG_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/slice_adder16.sv
// ============================================================================
// Module   : slice_adder16
// Brief    : Combinational 16-bit adder with carry-in and carry-out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slice_adder16
    import wallace_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W:0] w_total;

    assign w_total     = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
    assign {cout, sum} = w_total;

endmodule

`default_nettype wire

// File: rtl/wallace_final_adder.sv
// ============================================================================
// Module   : wallace_final_adder
// Brief    : Multi-cycle final adder resolving the Wallace-tree carry-save pair
//            one 16-bit slice per cycle. WALLACE_FINAL_HI_EN enables the upper
//            32 product bits (4 slices); otherwise only the low 32 (2 slices).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wallace_final_adder
    import wallace_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_sum,
    input  logic [63:0]       in_carry,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_lo,
    output logic [31:0]       out_hi,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

`ifdef WALLACE_FINAL_HI_EN
    localparam int NSLICE = PROD_W / SLICE_W;
`else
    localparam int NSLICE = PROD_W / SLICE_W / 2;
`endif
    localparam int              RES_W  = NSLICE * SLICE_W;
    localparam int              CNT_W  = $clog2(NSLICE);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NSLICE - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [RES_W-1:0]   r_sum;
    logic [RES_W-1:0]   r_carry;
    logic [RES_W-1:0]   r_acc;
    logic [RES_W-1:0]   r_out;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_cin;
    logic [TAG_W-1:0]   r_tag_in;
    logic [TAG_W-1:0]   r_out_tag;
    logic [SLICE_W-1:0] w_slice;
    logic               w_cout;
    logic               w_accept;
    logic               w_step;

    assign w_accept = (r_state == IDLE) && in_valid && !flush;
    assign w_step   = (r_state == ADD) && !flush;

    // Operands shift right each cycle, so the adder always sees the low slice.
    slice_adder16 u_slice_adder (
        .a    (r_sum[SLICE_W-1:0]),
        .b    (r_carry[SLICE_W-1:0]),
        .cin  (r_cin),
        .sum  (w_slice),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (in_valid)        w_next_state = ADD;
                ADD:     if (r_cnt == C_LAST) w_next_state = DONE;
                DONE:    if (out_ready)       w_next_state = IDLE;
                default:                      w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum     <= '0;
            r_carry   <= '0;
            r_acc     <= '0;
            r_out     <= '0;
            r_cnt     <= '0;
            r_cin     <= 1'b0;
            r_tag_in  <= '0;
            r_out_tag <= '0;
        end else if (w_accept) begin
            r_sum    <= in_sum[RES_W-1:0];
            r_carry  <= in_carry[RES_W-1:0];
            r_tag_in <= in_tag;
            r_cnt    <= '0;
            r_cin    <= 1'b0;
        end else if (w_step) begin
            r_sum   <= r_sum >> SLICE_W;
            r_carry <= r_carry >> SLICE_W;
            r_acc   <= {w_slice, r_acc[RES_W-1:SLICE_W]};
            r_cin   <= w_cout;
            r_cnt   <= r_cnt + 1'b1;
            // Outputs move only when a new product completes.
            if (r_cnt == C_LAST) begin
                r_out     <= {w_slice, r_acc[RES_W-1:SLICE_W]};
                r_out_tag <= r_tag_in;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_lo    = r_out[31:0];
    assign out_tag   = r_out_tag;

`ifdef WALLACE_FINAL_HI_EN
    assign out_hi = r_out[63:32];
`else
    logic w_unused_hi;
    assign w_unused_hi = ^{in_sum[PROD_W-1:RES_W], in_carry[PROD_W-1:RES_W]};
    assign out_hi      = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wallace_final_adder.sv
// ============================================================================
// Module   : tb_wallace_final_adder
// Brief    : Directed self-checking bench for wallace_final_adder; expected
//            values follow WALLACE_FINAL_HI_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wallace_final_adder;

`ifdef WALLACE_FINAL_HI_EN
    localparam int NSL    = 4;
    localparam int PERIOD = 6;
`else
    localparam int NSL    = 2;
    localparam int PERIOD = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_sum = '0;
    logic [63:0] in_carry = '0;
    logic [3:0]  in_tag = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_lo;
    logic [31:0] out_hi;
    logic [3:0]  out_tag;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    wallace_final_adder #(.TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lo    (out_lo),
        .out_hi    (out_hi),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Issue one pair, wait for DONE and check latency and result.
    task automatic do_op(input string name, input logic [63:0] s, input logic [63:0] c,
                         input logic [3:0] tag, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
        int lat;
        chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_sum   = s;
        in_carry = c;
        in_tag   = tag;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(NSL));
        chk({name, "_lo"}, 64'(out_lo), 64'(exp_lo));
        chk({name, "_hi"}, 64'(out_hi), 64'(exp_hi));
        chk({name, "_tag"}, 64'(out_tag), 64'(tag));
    endtask

    initial begin
        int got;
        int cyc;
        int last_cyc;
        logic [3:0] exp_tag;
        logic [3:0] send_tag;

        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_lo", 64'(out_lo), 64'd0);
        chk("rst_out_hi", 64'(out_hi), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);

        // Carry into bit 0 only; upper half passes straight through.
`ifdef WALLACE_FINAL_HI_EN
        do_op("basic", 64'hFFFF_FFFE_0000_0000, 64'h1, 4'd3, 32'h0000_0001, 32'hFFFF_FFFE);
`else
        do_op("basic", 64'hFFFF_FFFE_0000_0000, 64'h1, 4'd3, 32'h0000_0001, 32'h0);
`endif
        chk("basic_busy", 64'(busy), 64'd1);
        chk("basic_in_ready_done", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("basic_release_valid", 64'(out_valid), 64'd0);
        chk("basic_release_ready", 64'(in_ready), 64'd1);
        chk("basic_hold_lo", 64'(out_lo), 64'h1);

        // Carry ripples across every slice boundary.
`ifdef WALLACE_FINAL_HI_EN
        do_op("ripple", 64'h0000_FFFF_FFFF_FFFF, 64'h1, 4'd2, 32'h0, 32'h0001_0000);
`else
        do_op("ripple", 64'h0000_FFFF_FFFF_FFFF, 64'h1, 4'd2, 32'h0, 32'h0);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Stall in DONE while a second pair is offered.
`ifdef WALLACE_FINAL_HI_EN
        do_op("stall", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1110, 4'd7,
              32'hABCD_F000, 32'h2345_6789);
`else
        do_op("stall", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1110, 4'd7,
              32'hABCD_F000, 32'h0);
`endif
        in_valid = 1'b1;
        in_sum   = '0;
        in_carry = '0;
        in_tag   = 4'd9;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_lo", 64'(out_lo), 64'hABCD_F000);
            chk("stall_tag", 64'(out_tag), 64'd7);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("stall_no_capture_busy", 64'(busy), 64'd0);
        chk("stall_no_capture_ready", 64'(in_ready), 64'd1);
        chk("stall_tag_kept", 64'(out_tag), 64'd7);

        // Flush during the second ADD cycle.
        in_valid = 1'b1;
        in_sum   = 64'h1;
        in_carry = 64'h0;
        in_tag   = 4'd5;
        step();
        in_valid = 1'b0;
        step();
        chk("flush_pre_busy", 64'(busy), 64'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_tag   = 4'd10;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_lo_kept", 64'(out_lo), 64'hABCD_F000);
        chk("flush_tag_kept", 64'(out_tag), 64'd7);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_quiet", 64'(out_valid), 64'd0);
        end
`ifdef WALLACE_FINAL_HI_EN
        do_op("post_flush", 64'h0000_0000_FFFF_FFFF, 64'h2, 4'd6, 32'h1, 32'h1);
`else
        do_op("post_flush", 64'h0000_0000_FFFF_FFFF, 64'h2, 4'd6, 32'h1, 32'h0);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset while holding a result in DONE.
`ifdef WALLACE_FINAL_HI_EN
        do_op("pre_rst", 64'h0000_0002_0000_0003, 64'h4, 4'd11, 32'h7, 32'h2);
`else
        do_op("pre_rst", 64'h0000_0002_0000_0003, 64'h4, 4'd11, 32'h7, 32'h0);
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_done_valid", 64'(out_valid), 64'd0);
        chk("rst_done_lo", 64'(out_lo), 64'd0);
        chk("rst_done_hi", 64'(out_hi), 64'd0);
        chk("rst_done_tag", 64'(out_tag), 64'd0);
        chk("rst_done_ready", 64'(in_ready), 64'd1);

        // Back-to-back throughput with the CDB always granting.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        send_tag  = 4'd1;
        exp_tag   = 4'd1;
        in_tag    = send_tag;
        in_sum    = 64'(send_tag);
        in_carry  = '0;
        got       = 0;
        cyc       = 0;
        last_cyc  = 0;
        while (got < 4 && cyc < 80) begin
            step();
            cyc++;
            if (out_valid) begin
                chk("tput_tag", 64'(out_tag), 64'(exp_tag));
                chk("tput_lo", 64'(out_lo), 64'(exp_tag));
                if (got > 0) chk("tput_period", 64'(cyc - last_cyc), 64'(PERIOD));
                last_cyc = cyc;
                got++;
                exp_tag++;
            end
            if (in_ready) begin
                send_tag++;
                in_tag = send_tag;
                in_sum = 64'(send_tag);
            end
        end
        chk("tput_count", 64'(got), 64'd4);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
